// File: rtl/ahb_sram_slave.sv
// AHB-lite style responder (8-bit data) mapping one address window onto a
// synchronous single-port SRAM, with programmable wait states and error replies.
module ahb_sram_slave #(
    parameter int                    ADDR_WID    = 24,
    parameter logic [ADDR_WID-1:0]   BASE_ADDR   = '0,
    parameter int                    MEM_AW      = 16,
    parameter int                    WAIT_CYCLES = 0,
    parameter int                    READ_ONLY   = 0
) (
    input  logic                clk,
    input  logic                hreset_n,
    input  logic                hsel,
    input  logic [ADDR_WID-1:0] haddr,
    input  logic                hwrite,
    input  logic                hburst,
    input  logic                htrans,
    input  logic [7:0]          hwdata,
    output logic                hready,
    output logic                hresp,
    output logic [7:0]          hrdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [7:0]          mem_wdata,
    input  logic [7:0]          mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_RD, S_RDATA, S_WR, S_ERR1, S_ERR2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_WID-1:0] addr_q, addr_d;
    logic                write_q, write_d;
    logic                burst_q, burst_d;
    logic                vld_q, vld_d;
    logic                err_q, err_d;
    logic [7:0]          hrdata_q, hrdata_d;

    logic                can_accept;
    logic                acc_err;
    logic                acc_seq;
    logic [ADDR_WID-1:0] off_full;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        burst_d    = burst_q;
        vld_d      = vld_q;
        err_d      = err_q;
        hrdata_d   = hrdata_q;
        hready     = 1'b1;
        hresp      = 1'b0;
        hrdata     = hrdata_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        can_accept = 1'b0;

        // Underflow of (haddr - base) lands in the upper bits, so one test covers both ends.
        off_full = haddr - BASE_ADDR;
        acc_err  = ((off_full >> MEM_AW) != '0) || (hwrite && (READ_ONLY != 0));
        acc_seq  = vld_q && !err_q && hburst && burst_q && (hwrite == write_q) &&
                   (haddr == addr_q + 1'b1);

        case (state_q)
            S_IDLE: can_accept = 1'b1;
            S_WAIT: begin
                hready = 1'b0;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = write_q ? S_WR : S_RD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RD: begin
                hready   = 1'b0;
                mem_en   = 1'b1;
                mem_addr = addr_q[MEM_AW-1:0] - BASE_ADDR[MEM_AW-1:0];
                state_d  = S_RDATA;
            end
            S_RDATA: begin
                hrdata     = mem_rdata;
                hrdata_d   = mem_rdata;
                can_accept = 1'b1;
                state_d    = S_IDLE;
            end
            S_WR: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = addr_q[MEM_AW-1:0] - BASE_ADDR[MEM_AW-1:0];
                mem_wdata  = hwdata;
                can_accept = 1'b1;
                state_d    = S_IDLE;
            end
            S_ERR1: begin
                hready  = 1'b0;
                hresp   = 1'b1;
                state_d = S_ERR2;
            end
            S_ERR2: begin
                hresp      = 1'b1;
                can_accept = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // hready is high in every accepting state, so this is the bus handshake.
        if (can_accept && hsel && htrans) begin
            addr_d  = haddr;
            write_d = hwrite;
            burst_d = hburst;
            vld_d   = 1'b1;
            err_d   = acc_err;
            if (acc_err) begin
                state_d = S_ERR1;
            end else if (!acc_seq && (WAIT_CYCLES > 0)) begin
                state_d = S_WAIT;
                cnt_d   = 4'(WAIT_CYCLES);
            end else begin
                state_d = hwrite ? S_WR : S_RD;
            end
        end
    end

    always_ff @(posedge clk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            burst_q  <= 1'b0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            burst_q  <= burst_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            hrdata_q <= hrdata_d;
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: four responder configurations share one bus and one SRAM
// model; only the instance picked by cur is ever selected.
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        hreset_n, hsel, hwrite, hburst, htrans;
    logic [23:0] haddr;
    logic [7:0]  hwdata;
    logic [1:0]  cur;

    logic        hready_v [4];
    logic        hresp_v  [4];
    logic [7:0]  hrdata_v [4];
    logic        mem_en_v [4];
    logic        mem_we_v [4];
    logic [15:0] mem_addr_v [4];
    logic [7:0]  mem_wdata_v [4];
    logic [7:0]  mem_rdata;

    logic        hready_c, hresp_c, mem_en_c, mem_we_c;
    logic [7:0]  hrdata_c, mem_wdata_c;
    logic [15:0] mem_addr_c;

    assign hready_c    = hready_v[cur];
    assign hresp_c     = hresp_v[cur];
    assign hrdata_c    = hrdata_v[cur];
    assign mem_en_c    = mem_en_v[cur];
    assign mem_we_c    = mem_we_v[cur];
    assign mem_addr_c  = mem_addr_v[cur];
    assign mem_wdata_c = mem_wdata_v[cur];

    // 0: no waits, 1: two waits, 2: three waits, 3: read-only
    for (genvar k = 0; k < 4; k++) begin : g_dut
        ahb_sram_slave #(
            .WAIT_CYCLES((k == 1) ? 2 : ((k == 2) ? 3 : 0)),
            .READ_ONLY  ((k == 3) ? 1 : 0)
        ) u_dut (
            .clk      (clk),
            .hreset_n (hreset_n),
            .hsel     (hsel && (cur == 2'(k))),
            .haddr    (haddr),
            .hwrite   (hwrite),
            .hburst   (hburst),
            .htrans   (htrans),
            .hwdata   (hwdata),
            .hready   (hready_v[k]),
            .hresp    (hresp_v[k]),
            .hrdata   (hrdata_v[k]),
            .mem_en   (mem_en_v[k]),
            .mem_we   (mem_we_v[k]),
            .mem_addr (mem_addr_v[k]),
            .mem_wdata(mem_wdata_v[k]),
            .mem_rdata(mem_rdata)
        );
    end

    logic [7:0] sram    [0:65535];
    logic [7:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (mem_en_c) begin
            if (mem_we_c) sram[mem_addr_c] <= mem_wdata_c;
            else          mem_rdata        <= sram[mem_addr_c];
        end
    end

    typedef struct {
        string      tag;
        logic       wr;
        logic       err;
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          n_en  = 0;
    int          n_we  = 0;
    logic [15:0] last_we_addr;
    logic [7:0]  last_we_data;
    logic        stall_hresp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: latency counted from the address-phase cycle to the completing cycle.
    initial begin
        bit   pend;
        int   stamp;
        exp_t e;
        pend  = 0;
        stamp = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!hreset_n) begin
                pend = 0;
                continue;
            end
            if (mem_en_c) n_en++;
            if (mem_en_c && mem_we_c) begin
                n_we++;
                last_we_addr = mem_addr_c;
                last_we_data = mem_wdata_c;
            end
            if (pend && !hready_c) stall_hresp = hresp_c;
            if (pend && hready_c) begin
                pend = 0;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.tag, "_lat"}, cyc - stamp, e.lat);
                    chk({e.tag, "_hresp"}, hresp_c, e.err);
                    if (!e.wr && !e.err) chk({e.tag, "_hrdata"}, hrdata_c, e.data);
                end
            end
            if (hsel && htrans && hready_c) begin
                pend  = 1;
                stamp = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one address phase and return just after it is accepted.
    task automatic xfer(input string tag, input logic [23:0] a, input logic w, input logic b,
                        input logic [7:0] wd, input logic err, input int lat);
        exp_t e;
        int   n;
        e.tag  = tag;
        e.wr   = w;
        e.err  = err;
        e.lat  = lat;
        e.data = ref_mem[a[15:0]];
        if (w && !err) ref_mem[a[15:0]] = wd;
        exp_q.push_back(e);
        hsel = 1'b1; htrans = 1'b1; haddr = a; hwrite = w; hburst = b;
        n = 0;
        @(negedge clk);
        while (!hready_c && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!hready_c) chk({tag, "_accept_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        hwdata = wd;
        hsel   = 1'b0;
        htrans = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        hsel = 1'b0; htrans = 1'b0;
        while (exp_q.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int         en0, we0;
        logic [7:0] sv;
        hreset_n = 1'b0; hsel = 1'b0; htrans = 1'b0; haddr = '0;
        hwrite = 1'b0; hburst = 1'b0; hwdata = '0; cur = '0;
        tick(2);
        for (int k = 0; k < 4; k++) begin
            cur = 2'(k);
            #1;
            chk($sformatf("rst%0d_hready", k), hready_c, 1);
            chk($sformatf("rst%0d_hresp", k), hresp_c, 0);
            chk($sformatf("rst%0d_hrdata", k), hrdata_c, 0);
            chk($sformatf("rst%0d_mem_en", k), mem_en_c, 0);
        end
        hreset_n = 1'b1;
        cur = 2'd0;
        tick(1);

        // seed through the zero-wait instance (pipelined single writes)
        xfer("seed05", 24'h05, 1, 0, 8'h77, 0, 1);
        xfer("seed20", 24'h20, 1, 0, 8'h33, 0, 1);
        for (int i = 0; i < 4; i++)
            xfer($sformatf("seed4%0d", i), 24'h40 + 24'(i), 1, 0, 8'hA0 + 8'(i), 0, 1);
        xfer("seed60", 24'h60, 1, 0, 8'h11, 0, 1);
        drain();

        we0 = n_we;
        xfer("wr10", 24'h10, 1, 0, 8'h5A, 0, 1);
        drain();
        chk("wr10_we_pulses", n_we - we0, 1);
        chk("wr10_mem_addr", last_we_addr, 16'h0010);
        chk("wr10_mem_wdata", last_we_data, 8'h5A);
        xfer("rd10", 24'h10, 0, 0, 8'h00, 0, 2);
        drain();
        xfer("wr12", 24'h12, 1, 0, 8'h99, 0, 1);
        drain();
        chk("hold_after_write", hrdata_c, 8'h5A);

        en0 = n_en;
        xfer("rd_oow", 24'h010000, 0, 0, 8'h00, 1, 2);
        drain();
        chk("oow_mem_en", n_en - en0, 0);
        chk("oow_err1_hresp", stall_hresp, 1);

        // two wait states
        cur = 2'd1;
        en0 = n_en;
        xfer("rd20", 24'h20, 0, 0, 8'h00, 0, 4);
        drain();
        chk("rd20_mem_en", n_en - en0, 1);
        en0 = n_en;
        xfer("b40", 24'h40, 0, 1, 8'h00, 0, 4);
        xfer("b41", 24'h41, 0, 1, 8'h00, 0, 2);
        xfer("b42", 24'h42, 0, 1, 8'h00, 0, 2);
        xfer("b43", 24'h43, 0, 1, 8'h00, 0, 2);
        drain();
        chk("burst_mem_en", n_en - en0, 4);
        xfer("bw50", 24'h50, 1, 1, 8'hC1, 0, 3);
        xfer("bw51", 24'h51, 1, 1, 8'hC2, 0, 1);
        tick(1);
        xfer("bw52", 24'h52, 1, 1, 8'hC3, 0, 1);
        drain();
        xfer("rd51", 24'h51, 0, 0, 8'h00, 0, 4);
        xfer("rd52", 24'h52, 0, 0, 8'h00, 0, 4);
        xfer("b60", 24'h60, 0, 1, 8'h00, 0, 4);
        xfer("b05_gap", 24'h05, 0, 1, 8'h00, 0, 4);
        drain();

        // read-only instance
        cur = 2'd3;
        we0 = n_we;
        xfer("ro_wr05", 24'h05, 1, 0, 8'hEE, 1, 2);
        xfer("ro_rd05", 24'h05, 0, 0, 8'h00, 0, 2);
        drain();
        chk("ro_we_pulses", n_we - we0, 0);

        // reset in the middle of a write's wait states
        cur = 2'd2;
        we0 = n_we;
        sv  = ref_mem[16'h60];
        xfer("rst_wr60", 24'h60, 1, 0, 8'h99, 0, 4);
        #3;
        hreset_n = 1'b0;
        #1;
        chk("midrst_hready", hready_c, 1);
        chk("midrst_hresp", hresp_c, 0);
        chk("midrst_mem_we", mem_we_c, 0);
        exp_q.delete();
        ref_mem[16'h60] = sv;
        tick(2);
        hreset_n = 1'b1;
        tick(8);
        chk("midrst_we_pulses", n_we - we0, 0);
        xfer("rst_rd60", 24'h60, 0, 0, 8'h00, 0, 5);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- Responder end of the shrinked AHB (8-bit data, 1-bit htrans/hburst) that the CPU bus unit initiates on.
- Decodes one address window and maps it onto a synchronous single-port SRAM (1-cycle read latency).
- Inserts programmable wait states; burst-sequential beats skip them.
- Returns a two-cycle error response for out-of-window or forbidden accesses.

Parameters:
ADDR_WID, 24, haddr width (set to 32 when the MMU is enabled)
BASE_ADDR, 0, window base; must be aligned to 2^MEM_AW
MEM_AW, 16, SRAM address width; window size is 2^MEM_AW bytes
WAIT_CYCLES, 0, stall cycles added to non-sequential data phases (0..15)
READ_ONLY, 0, 1 = any write returns an error

Ports:
clk  in  1  clock; all logic on rising edge
hreset_n  in  1  asynchronous active-low reset
hsel  in  1  slave select from the bus decoder
haddr  in  ADDR_WID  transfer address (address phase)
hwrite  in  1  1 = write, 0 = read (address phase)
hburst  in  1  1 = beat belongs to an incrementing burst
htrans  in  1  1 = active transfer, 0 = idle
hwdata  in  8  write data (data phase)
hready  out  1  1 = data phase completes / address phase accepted
hresp  out  1  1 = error response
hrdata  out  8  read data
mem_en  out  1  SRAM access strobe
mem_we  out  1  SRAM write enable
mem_addr  out  MEM_AW  SRAM address
mem_wdata  out  8  SRAM write data
mem_rdata  in  8  SRAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Accept: at a rising edge where hsel=1, htrans=1 and hready=1. Latch addr, hwrite, hburst. Otherwise no transfer.
- Error check at accept:
  - haddr outside [BASE_ADDR, BASE_ADDR+2^MEM_AW) → error.
  - hwrite=1 with READ_ONLY=1 → error.
- Sequential check at accept: all of the following → seq.
  - hburst=1 and the previous accepted transfer had hburst=1.
  - Same hwrite as the previous transfer.
  - haddr = previous haddr + 1.
  - Previous transfer completed without error.
- States: IDLE, WAIT, RD, RDATA, WR, ERR1, ERR2.
- Next state from any accept:
  - error → ERR1.
  - Non-seq with WAIT_CYCLES>0 → WAIT, cnt=WAIT_CYCLES.
  - Otherwise read → RD, write → WR.
- Per-state outputs and transitions:
  - IDLE: hready=1, hresp=0, mem_en=0. Accept → per rule; else stay.
  - WAIT: hready=0. cnt decrements each cycle; when cnt=1, next is RD (read) or WR (write).
  - RD: hready=0, mem_en=1, mem_we=0, mem_addr=latched addr[MEM_AW-1:0] → RDATA.
  - RDATA: hready=1; hrdata=mem_rdata combinationally, also captured into the hold register. Accept → per rule; else IDLE.
  - WR: hready=1, mem_en=1, mem_we=1, mem_addr=latched addr, mem_wdata=hwdata. Accept → per rule; else IDLE.
  - ERR1: hready=0, hresp=1, no memory access → ERR2.
  - ERR2: hready=1, hresp=1. Accept → per rule; else IDLE.
- Latency, address phase at T:
  - Read, WAIT_CYCLES=N non-seq: hready=0 for N+1 cycles; data with hready=1 at T+N+2.
  - Seq read: data at T+2.
  - Write: completes at T+N+1 (non-seq) or T+1 (seq).
- hrdata outside RDATA holds the last read value. Write data is never reflected on hrdata.
- Pipelining: an address phase in a hready=1 data-phase cycle (RDATA, WR, ERR2) is accepted with no bubble.
- Idle transfers (htrans=0) during a burst do not break seq tracking. Any non-seq accept or error clears it.
- mem_en/mem_we are asserted only in RD/WR; never during WAIT/ERR.
- Reset (asynchronous, any state) forces:
  - state=IDLE, hready=1, hresp=0, hrdata=0;
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - cnt=0, seq history cleared.
  - An in-flight write is dropped.
- Address arithmetic: seq compare uses full ADDR_WID and wraps modulo 2^ADDR_WID. The mem_addr offset is addr minus BASE_ADDR, truncated to MEM_AW.

Test Plan:
- WAIT_CYCLES=0: write 0x5A @0x000010 then read @0x000010 → WR cycle with mem_we=1, mem_addr=0x0010; read shows hready 0,1 and hrdata=0x5A at T+2.
- WAIT_CYCLES=2, read @0x000020 holding 0x33 → hready low 3 cycles, hrdata=0x33 with hready=1 at T+4, one mem_en pulse.
- WAIT_CYCLES=2, 4-beat read burst (hburst=1) 0x40..0x43 → first beat at T+4, beats 2-4 each after 1 stall, correct bytes, wait skipped on beats 2-4.
- BASE_ADDR=0, MEM_AW=16, read @0x010000 → ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1); mem_en never asserted.
- READ_ONLY=1, write @0x000005 → two-cycle error, mem_we stays 0. A following read @0x000005 is accepted in ERR2 and returns SRAM content.
- WAIT_CYCLES=3, assert hreset_n=0 mid-WAIT of a write → immediate IDLE, hready=1, hresp=0; no mem_we pulse after release.
